// File: rtl/rv_decode_pkg.sv
// Shared constants for the RV32I decode stage: opcodes, instruction field positions,
// immediate formats and the immediate assembly helper.
package rv_decode_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam int OPC_LSB    = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;
    localparam int REG_FIELD_W = 5;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    function automatic logic [31:0] imm32(input logic [31:0] i, input imm_fmt_e fmt);
        logic [31:0] r;
        case (fmt)
            IMM_I:   r = {{20{i[31]}}, i[31:20]};
            IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   r = {i[31:12], 12'b0};
            IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// Pending-writeback register scoreboard; one busy bit per architectural register.
// Hazard query sees this cycle's clears so a same-cycle writeback releases the stall.
module rv_scoreboard #(
    parameter int NUM_REGS       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ENABLE         = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      set_en,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic                      flush_clr_en,
    input  logic [REG_ADDR_WIDTH-1:0] flush_clr_addr,
    input  logic                      q_rs1_en,
    input  logic [REG_ADDR_WIDTH-1:0] q_rs1,
    input  logic                      q_rs2_en,
    input  logic [REG_ADDR_WIDTH-1:0] q_rs2,
    input  logic                      q_rd_en,
    input  logic [REG_ADDR_WIDTH-1:0] q_rd,
    output logic                      hazard
);

    generate
        if (ENABLE != 0) begin : g_sb
            logic [NUM_REGS-1:0] busy_q;
            logic [NUM_REGS-1:0] clr_mask;
            logic [NUM_REGS-1:0] set_mask;
            logic [NUM_REGS-1:0] live;

            always_comb begin
                clr_mask = '0;
                set_mask = '0;
                if (wb_en && wb_addr != '0)
                    clr_mask[wb_addr] = 1'b1;
                if (flush_clr_en && flush_clr_addr != '0)
                    clr_mask[flush_clr_addr] = 1'b1;
                if (set_en && set_addr != '0)
                    set_mask[set_addr] = 1'b1;
            end

            assign live = busy_q & ~clr_mask;

            // x0 never creates a dependency
            assign hazard = (q_rs1_en && q_rs1 != '0 && live[q_rs1]) ||
                            (q_rs2_en && q_rs2 != '0 && live[q_rs2]) ||
                            (q_rd_en  && q_rd  != '0 && live[q_rd]);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    busy_q <= '0;
                else
                    busy_q <= (busy_q & ~clr_mask) | set_mask;
            end
        end else begin : g_nosb
            assign hazard = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/rv_decode_pipe.sv
// RV32I decode stage: combinational decode into one output register with valid/ready
// handshakes on both sides and a scoreboard holding back RAW/WAW hazards.
module rv_decode_pipe
    import rv_decode_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_REGS       = 32,
    parameter int SCOREBOARD_EN  = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [PC_WIDTH-1:0]       in_pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PC_WIDTH-1:0]       out_pc,
    output logic [6:0]                out_opcode,
    output logic [2:0]                out_funct3,
    output logic [6:0]                out_funct7,
    output logic [XLEN-1:0]           out_imm,
    output logic [REG_ADDR_WIDTH-1:0] out_rs1,
    output logic [REG_ADDR_WIDTH-1:0] out_rs2,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_rs1_valid,
    output logic                      out_rs2_valid,
    output logic                      out_rd_valid,
    output logic                      out_illegal,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      decoder_stall
);

    logic [6:0]             raw_opc;
    logic [2:0]             raw_f3;
    logic [6:0]             raw_f7;
    logic [REG_FIELD_W-1:0] raw_rd, raw_rs1, raw_rs2;

    assign raw_opc = in_instr[OPC_LSB    +: 7];
    assign raw_rd  = in_instr[RD_LSB     +: REG_FIELD_W];
    assign raw_f3  = in_instr[FUNCT3_LSB +: 3];
    assign raw_rs1 = in_instr[RS1_LSB    +: REG_FIELD_W];
    assign raw_rs2 = in_instr[RS2_LSB    +: REG_FIELD_W];
    assign raw_f7  = in_instr[FUNCT7_LSB +: 7];

    logic [6:0]                d_opcode;
    logic [2:0]                d_funct3;
    logic [6:0]                d_funct7;
    imm_fmt_e                  d_fmt;
    logic                      use_rs1, use_rs2, use_rd, d_illegal;
    logic [XLEN-1:0]           d_imm;
    logic [REG_ADDR_WIDTH-1:0] d_rs1, d_rs2, d_rd;
    logic                      d_rd_valid;

    always_comb begin
        d_funct3  = raw_f3;
        d_funct7  = '0;
        d_fmt     = IMM_NONE;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        use_rd    = 1'b0;
        d_illegal = 1'b0;
        case (raw_opc)
            OPC_OP: begin
                {use_rs1, use_rs2, use_rd} = 3'b111;
                d_funct7  = raw_f7;
                d_illegal = (raw_f7 != FUNCT7_BASE) && (raw_f7 != FUNCT7_ALT);
            end
            OPC_OP_IMM: begin
                {use_rs1, use_rd} = 2'b11;
                d_fmt = IMM_I;
                // shifts carry the arithmetic/logical select in the funct7 field
                if (raw_f3[1:0] == 2'b01)
                    d_funct7 = raw_f7;
            end
            OPC_LOAD, OPC_JALR: begin
                {use_rs1, use_rd} = 2'b11;
                d_fmt = IMM_I;
            end
            OPC_STORE: begin
                {use_rs1, use_rs2} = 2'b11;
                d_fmt = IMM_S;
            end
            OPC_BRANCH: begin
                {use_rs1, use_rs2} = 2'b11;
                d_fmt = IMM_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                use_rd   = 1'b1;
                d_fmt    = IMM_U;
                d_funct3 = '0;
            end
            OPC_JAL: begin
                use_rd   = 1'b1;
                d_fmt    = IMM_J;
                d_funct3 = '0;
            end
            OPC_MISC_MEM: d_fmt = IMM_I;
            OPC_SYSTEM: begin
                d_fmt   = IMM_I;
                use_rd  = (raw_f3 != 3'b000);
                use_rs1 = (raw_f3 != 3'b000) && !raw_f3[2];
            end
            default: d_illegal = 1'b1;
        endcase
        if (d_illegal) begin
            d_funct3 = '0;
            d_funct7 = '0;
            d_fmt    = IMM_NONE;
            use_rs1  = 1'b0;
            use_rs2  = 1'b0;
            use_rd   = 1'b0;
        end
    end

    assign d_opcode   = d_illegal ? 7'd0 : raw_opc;
    assign d_imm      = (d_fmt == IMM_NONE) ? '0 : XLEN'($signed(imm32(in_instr, d_fmt)));
    assign d_rs1      = use_rs1 ? REG_ADDR_WIDTH'(raw_rs1) : '0;
    assign d_rs2      = use_rs2 ? REG_ADDR_WIDTH'(raw_rs2) : '0;
    assign d_rd       = use_rd  ? REG_ADDR_WIDTH'(raw_rd)  : '0;
    assign d_rd_valid = use_rd && (raw_rd != '0);

    logic hazard, accept;

    assign in_ready      = !flush && !hazard && (!out_valid || out_ready);
    assign accept        = in_valid && in_ready;
    assign decoder_stall = in_valid && hazard;

    rv_scoreboard #(
        .NUM_REGS       (NUM_REGS),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .ENABLE         (SCOREBOARD_EN)
    ) u_scoreboard (
        .clk            (clk),
        .reset_n        (reset_n),
        .set_en         (accept && d_rd_valid),
        .set_addr       (d_rd),
        .wb_en          (wb_valid),
        .wb_addr        (wb_rd),
        .flush_clr_en   (flush && out_valid && out_rd_valid),
        .flush_clr_addr (out_rd),
        .q_rs1_en       (use_rs1),
        .q_rs1          (d_rs1),
        .q_rs2_en       (use_rs2),
        .q_rs2          (d_rs2),
        .q_rd_en        (d_rd_valid),
        .q_rd           (d_rd),
        .hazard         (hazard)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_opcode    <= '0;
            out_funct3    <= '0;
            out_funct7    <= '0;
            out_imm       <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_rs1_valid <= 1'b0;
            out_rs2_valid <= 1'b0;
            out_rd_valid  <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_opcode    <= d_opcode;
            out_funct3    <= d_funct3;
            out_funct7    <= d_funct7;
            out_imm       <= d_imm;
            out_rs1       <= d_rs1;
            out_rs2       <= d_rs2;
            out_rd        <= d_rd;
            out_rs1_valid <= use_rs1;
            out_rs2_valid <= use_rs2;
            out_rd_valid  <= d_rd_valid;
            out_illegal   <= d_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_decode_pipe.sv
// Directed-vector bench for rv_decode_pipe with hand-computed expectations.
module tb_rv_decode_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_rs1_valid, out_rs2_valid, out_rd_valid;
    logic        out_illegal;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        decoder_stall;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_decode_pipe dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_opcode    (out_opcode),
        .out_funct3    (out_funct3),
        .out_funct7    (out_funct7),
        .out_imm       (out_imm),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_rs1_valid (out_rs1_valid),
        .out_rs2_valid (out_rs2_valid),
        .out_rd_valid  (out_rd_valid),
        .out_illegal   (out_illegal),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .decoder_stall (decoder_stall)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_in_ready", in_ready, 1);
        reset_n = 1'b1;
        tick();

        // addi x1,x0,5
        present(32'h0050_0093, 32'h100);
        #1 chk("addi_in_ready", in_ready, 1);
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_opcode", out_opcode, 7'b0010011);
        chk("addi_rd", out_rd, 1);
        chk("addi_imm", out_imm, 5);
        chk("addi_rs1_valid", out_rs1_valid, 1);
        chk("addi_rs2_valid", out_rs2_valid, 0);
        chk("addi_pc", out_pc, 32'h100);

        // addi x2,x0,-1
        present(32'hFFF0_0113, 32'h104);
        tick();
        chk("addi_neg_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_neg_rd", out_rd, 2);

        // beq x0,x0,-4
        present(32'hFE00_0EE3, 32'h108);
        tick();
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        chk("beq_opcode", out_opcode, 7'b1100011);
        chk("beq_rd_valid", out_rd_valid, 0);
        chk("beq_rs2_valid", out_rs2_valid, 1);

        // retire x1 and x2 so the next test starts clean
        in_valid = 1'b0;
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        tick();
        chk("drain_valid", out_valid, 0);
        wb_rd = 5'd2;
        tick();
        wb_valid = 1'b0;

        // RAW stall released by same-cycle writeback
        present(32'h0050_0093, 32'h200);
        tick();
        present(32'h0020_81B3, 32'h204);
        #1;
        chk("raw_in_ready", in_ready, 0);
        chk("raw_stall", decoder_stall, 1);
        tick();
        chk("raw_out_drained", out_valid, 0);
        chk("raw_stall_hold", decoder_stall, 1);
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        #1;
        chk("raw_wb_in_ready", in_ready, 1);
        chk("raw_wb_stall", decoder_stall, 0);
        tick();
        wb_valid = 1'b0;
        chk("add_valid", out_valid, 1);
        chk("add_opcode", out_opcode, 7'b0110011);
        chk("add_regs", {out_rd, out_rs1, out_rs2}, {5'd3, 5'd1, 5'd2});
        chk("add_funct7", out_funct7, 0);

        // backpressure: addi x4,x0,7 waits while add is held
        out_ready = 1'b0;
        present(32'h0070_0213, 32'h300);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready", in_ready, 0);
            tick();
            chk("bp_hold_rd", out_rd, 3);
            chk("bp_hold_pc", out_pc, 32'h204);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        tick();
        chk("bp_next_rd", out_rd, 4);
        chk("bp_next_imm", out_imm, 7);
        chk("bp_next_pc", out_pc, 32'h300);

        // illegal opcode; retire x3 meanwhile
        present(32'h0000_007F, 32'h400);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        tick();
        wb_valid = 1'b0;
        chk("ill_flag", out_illegal, 1);
        chk("ill_valids", {out_rs1_valid, out_rs2_valid, out_rd_valid}, 0);
        chk("ill_opcode", out_opcode, 0);

        present(32'h4020_81B3, 32'h404);
        tick();
        chk("sub_illegal", out_illegal, 0);
        chk("sub_funct7", out_funct7, 7'b0100000);
        chk("sub_opcode", out_opcode, 7'b0110011);

        // bad funct7: decodes illegal, so no hazard on the still-pending x3
        present(32'h2020_81B3, 32'h408);
        #1 chk("badf7_stall", decoder_stall, 0);
        tick();
        chk("badf7_illegal", out_illegal, 1);
        chk("badf7_funct7", out_funct7, 0);

        // lui x7,0x12345
        present(32'h1234_53B7, 32'h40C);
        tick();
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_rd", out_rd, 7);
        chk("lui_rs1_valid", out_rs1_valid, 0);

        // flush a held addi x1 and confirm x1 is released
        present(32'h0050_0093, 32'h500);
        tick();
        chk("fl_pre_valid", out_valid, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        #1 chk("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        present(32'h0000_8293, 32'h504);
        #1;
        chk("fl_x1_free_stall", decoder_stall, 0);
        chk("fl_x1_free_ready", in_ready, 1);
        tick();
        chk("fl_next_rd", out_rd, 5);

        // stall on x5, then asynchronous reset in mid-cycle
        present(32'h0012_8313, 32'h508);
        #1 chk("rst_pre_stall", decoder_stall, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_rd", out_rd, 0);
        chk("async_rst_stall", decoder_stall, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
